cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream handshake. It is the successor to the fixed 4-bit lookahead adder. The block splits a WIDTH-bit operation into 4-bit lookahead groups and registers the carry between pipeline stages, so wide adds close timing at full clock rate. It sits between operand-fetch logic and the datapath writeback, and sustains one operation per cycle when not back-pressured.

---
 rtl/cla_pkg.sv | 10 +
 rtl/cla_stage.sv | 32 +++
 rtl/cla_pipe_adder.sv | 91 +++++++++
 tb/tb_cla_pipe_adder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;
    localparam int GROUP_W = 4;
    function automatic int calc_stages(input int width, input int gps);
        return width / (GROUP_W * gps);
    endfunction
    function automatic bit width_ok(input int width, input int gps);
        return (width % (GROUP_W * gps)) == 0;
    endfunction
endpackage

// File: rtl/cla_stage.sv
// cla_stage: combinational slice adder built from 4-bit lookahead groups rippling between groups.
module cla_stage import cla_pkg::*; #(
    parameter int GPS = 2
) (
    input  logic [GROUP_W*GPS-1:0] a_i,
    input  logic [GROUP_W*GPS-1:0] b_i,
    input  logic                   ci_i,
    output logic [GROUP_W*GPS-1:0] s_o,
    output logic                   co_o,
    output logic                   cm_o
);
    logic [GPS:0] gc;
    assign gc[0] = ci_i;
    assign co_o = gc[GPS];
    for (genvar j = 0; j < GPS; j++) begin : g_grp
        logic [3:0] p, g;
        logic [4:0] c;
        assign p = a_i[j*GROUP_W +: GROUP_W] ^ b_i[j*GROUP_W +: GROUP_W];
        assign g = a_i[j*GROUP_W +: GROUP_W] & b_i[j*GROUP_W +: GROUP_W];
        assign c[0] = gc[j];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                    | (&p & c[0]);
        assign s_o[j*GROUP_W +: GROUP_W] = p ^ c[3:0];
        assign gc[j+1] = c[4];
        if (j == GPS - 1) begin : g_msb
            assign cm_o = c[3];
        end
    end
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead add/subtract with valid/ready handshake.
// Each stage adds one slice; unadded operand bits and finished sum bits travel along.
module cla_pipe_adder import cla_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int GPS   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);
    localparam int SW = GROUP_W * GPS;
    localparam int STAGES = calc_stages(WIDTH, GPS);
    localparam logic [WIDTH-1:0] SLICE_M = WIDTH'({SW{1'b1}});
    if (!width_ok(WIDTH, GPS)) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of 4*GPS");
    end
    logic             v_q[STAGES], c_q[STAGES], o_q[STAGES];
    logic             v_d[STAGES], c_d[STAGES], o_d[STAGES];
    logic [WIDTH-1:0] a_q[STAGES], b_q[STAGES], s_q[STAGES];
    logic [WIDTH-1:0] a_d[STAGES], b_d[STAGES], s_d[STAGES];
    logic             rdy[STAGES+1];
    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];
    assign out_valid   = v_q[STAGES-1];
    assign s           = s_q[STAGES-1];
    assign co          = c_q[STAGES-1];
    assign ovf         = o_q[STAGES-1];
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic             v_in, c_in, cout, cm;
        logic [WIDTH-1:0] a_in, b_in, s_in;
        logic [SW-1:0]    sum;
        if (k == 0) begin : g_in
            assign v_in = in_valid;
            assign a_in = a;
            assign b_in = sub ? ~b : b;
            assign c_in = sub | ci;
            assign s_in = '0;
        end else begin : g_in
            assign v_in = v_q[k-1];
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign c_in = c_q[k-1];
            assign s_in = s_q[k-1];
        end
        cla_stage #(.GPS(GPS)) u_stage (
            .a_i  (a_in[k*SW +: SW]),
            .b_i  (b_in[k*SW +: SW]),
            .ci_i (c_in),
            .s_o  (sum),
            .co_o (cout),
            .cm_o (cm)
        );
        assign v_d[k] = v_in;
        assign a_d[k] = a_in;
        assign b_d[k] = b_in;
        assign c_d[k] = cout;
        // only the last stage's value reaches ovf; earlier ones are overwritten downstream
        assign o_d[k] = cout ^ cm;
        assign s_d[k] = (s_in & ~(SLICE_M << (k*SW))) | (WIDTH'(sum) << (k*SW));
        assign rdy[k] = !v_q[k] || rdy[k+1];
    end
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (reset) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                o_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end else if (rdy[k]) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                o_q[k] <= o_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed table vectors, stream/backpressure sequences and a 32-bit GPS sweep.
module tb_cla_pipe_adder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1, ci = 1'b0, sub = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, co, ovf;
    logic [15:0] s;
    logic [31:0] a32 = '0, b32 = '0;
    logic        ci32 = 1'b0, sub32 = 1'b0, iv32 = 1'b0;
    logic        ir1, ir2, ir8, ov1, ov2, ov8, co1, co2, co8, of1, of2, of8;
    logic [31:0] s1, s2, s8;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(16), .GPS(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .ovf(ovf));
    cla_pipe_adder #(.WIDTH(32), .GPS(1)) d1 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir1), .a(a32), .b(b32),
        .ci(ci32), .sub(sub32), .out_valid(ov1), .out_ready(1'b1), .s(s1), .co(co1), .ovf(of1));
    cla_pipe_adder #(.WIDTH(32), .GPS(2)) d2 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir2), .a(a32), .b(b32),
        .ci(ci32), .sub(sub32), .out_valid(ov2), .out_ready(1'b1), .s(s2), .co(co2), .ovf(of2));
    cla_pipe_adder #(.WIDTH(32), .GPS(8)) d8 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir8), .a(a32), .b(b32),
        .ci(ci32), .sub(sub32), .out_valid(ov8), .out_ready(1'b1), .s(s8), .co(co8), .ovf(of8));

    typedef struct {
        logic [15:0] a, b;
        logic        ci, sub;
        logic [15:0] s;
        logic        co, ovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] model16(input logic [15:0] x, y, input logic c, sb);
        logic [15:0] be;
        logic [16:0] r;
        be = sb ? ~y : y;
        r = {1'b0, x} + {1'b0, be} + 17'(sb ? 1'b1 : c);
        return {r[15:0], r[16], (x[15] == be[15]) && (r[15] != x[15])};
    endfunction

    function automatic logic [33:0] model32(input logic [31:0] x, y, input logic c, sb);
        logic [31:0] be;
        logic [32:0] r;
        be = sb ? ~y : y;
        r = {1'b0, x} + {1'b0, be} + 33'(sb ? 1'b1 : c);
        return {r[31:0], r[32], (x[31] == be[31]) && (r[31] != x[31])};
    endfunction

    task automatic drive(input logic [15:0] x, y, input logic c, sb);
        a = x; b = y; ci = c; sub = sb; in_valid = 1'b1;
    endtask

    task automatic sweep(input logic [31:0] x, y, input logic c, sb);
        logic [33:0] exp, r1, r2, r8;
        int l1, l2, l8;
        exp = model32(x, y, c, sb);
        l1 = 0; l2 = 0; l8 = 0; r1 = '0; r2 = '0; r8 = '0;
        @(negedge clk);
        a32 = x; b32 = y; ci32 = c; sub32 = sb; iv32 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            iv32 = 1'b0;
            if (ov1 && l1 == 0) begin l1 = n; r1 = {s1, co1, of1}; end
            if (ov2 && l2 == 0) begin l2 = n; r2 = {s2, co2, of2}; end
            if (ov8 && l8 == 0) begin l8 = n; r8 = {s8, co8, of8}; end
        end
        chk("lat_gps1", 64'(l1), 64'd8);
        chk("lat_gps2", 64'(l2), 64'd4);
        chk("lat_gps8", 64'(l8), 64'd1);
        chk("res_gps1", 64'(r1), 64'(exp));
        chk("res_gps2", 64'(r2), 64'(exp));
        chk("res_gps8", 64'(r8), 64'(exp));
    endtask

    vec_t        tbl[10];
    logic [17:0] exp_q[100];
    logic [17:0] ea, eb, ec;

    initial begin
        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[6] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[8] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0};
        tbl[9] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_s", 64'({s, co, ovf}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_early", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_res", i), 64'({s, co, ovf}), 64'({tbl[i].s, tbl[i].co, tbl[i].ovf}));
        end

        // reset with two operations held in flight
        @(negedge clk);
        out_ready = 1'b0;
        drive(16'h0101, 16'h0202, 1'b0, 1'b0);
        @(negedge clk);
        drive(16'h0303, 16'h0404, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        chk("midrst_s", 64'({s, co, ovf}), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end

        // back-to-back stream
        for (int n = 0; n < 102; n++) begin
            if (n >= 2) begin
                chk("stream_valid", 64'(out_valid), 64'd1);
                chk($sformatf("stream_res%0d", n - 2), 64'({s, co, ovf}), 64'(exp_q[n-2]));
            end
            if (n < 100) begin
                drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                exp_q[n] = model16(a, b, ci, sub);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream_end", 64'(out_valid), 64'd0);

        // backpressure
        ea = model16(16'h1111, 16'h2222, 1'b0, 1'b0);
        eb = model16(16'h8000, 16'h0001, 1'b0, 1'b1);
        ec = model16(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        drive(16'h8000, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        drive(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_frozen", 64'({s, co, ovf}), 64'(ea));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        chk("bp_first", 64'({out_valid, s, co, ovf}), 64'({1'b1, ea}));
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second", 64'({out_valid, s, co, ovf}), 64'({1'b1, eb}));
        @(negedge clk);
        chk("bp_third", 64'({out_valid, s, co, ovf}), 64'({1'b1, ec}));
        @(negedge clk);
        chk("bp_no_dup", 64'(out_valid), 64'd0);

        // 32-bit sweep across GPS values
        sweep(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        sweep(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        sweep(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            sweep($urandom, $urandom, 1'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
